// File: rtl/rom68k_pkg.sv
// Shared definitions for the 68k boot/code ROM arbiter.
//  state_e : arbiter sequencing states (IDLE -> ISSUE -> WAIT -> DONE)
//  grant_e : which requester owns the current ROM access
//  ROM_AW  : default ROM word-address width (1024 x 16 ROM)
package rom68k_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_e;

    localparam int ROM_AW = 10;

endpackage

// File: rtl/rom68k_arb_rr_arb2.sv
// Two-way round-robin pick (purely combinational).
// Ports:
//  cpu_req, dbg_req : pending requests
//  last_grant       : side served most recently
//  pick_valid       : at least one request pending
//  pick_grant       : chosen side; on a tie the side that was not served last
module rr_arb2
    import rom68k_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  grant_e last_grant,
    output logic   pick_valid,
    output grant_e pick_grant
);

    always_comb begin
        pick_valid = cpu_req | dbg_req;
        pick_grant = GNT_CPU;
        if (cpu_req && dbg_req) begin
            pick_grant = (last_grant == GNT_CPU) ? GNT_DBG : GNT_CPU;
        end else if (dbg_req) begin
            pick_grant = GNT_DBG;
        end
    end

endmodule

// File: rtl/rom68k_arb.sv
// Arbiter sharing the single-port 68k boot/code ROM between the CPU boot-fetch
// path and the debug/loader path. One ROM read is outstanding at a time; the
// returned word is registered into the granted side's data register and
// signalled with a one-cycle ack. A watchdog turns a missing ROM reply into
// an error reply carrying ERR_DATA.
// Ports:
//  clk, rst              : clock, synchronous active-high reset
//  cpu_req/addr/ack/data : CPU read handshake (req held until ack)
//  dbg_req/addr/ack/data : debug read handshake (same rules)
//  rom_req/addr          : ROM read strobe (one pulse) and held address
//  rom_ack/data          : ROM reply
//  timeout_err           : pulses together with an error ack
module rom68k_arb
    import rom68k_pkg::*;
#(
    parameter int          AW       = ROM_AW,
    parameter int          TIMEOUT  = 15,
    parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [15:0]   cpu_data,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_ack,
    output logic [15:0]   dbg_data,
    output logic          rom_req,
    output logic [AW-1:0] rom_addr,
    input  logic          rom_ack,
    input  logic [15:0]   rom_data,
    output logic          timeout_err
);

    // Last WAIT cycle count before the error exit is taken.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_e        state_q,       state_d;
    grant_e        grant_q,       grant_d;
    grant_e        last_grant_q,  last_grant_d;
    logic [AW-1:0] rom_addr_q,    rom_addr_d;
    logic          rom_req_q,     rom_req_d;
    logic [7:0]    wdog_q,        wdog_d;
    logic [15:0]   cpu_data_q,    cpu_data_d;
    logic [15:0]   dbg_data_q,    dbg_data_d;
    logic          cpu_ack_q,     cpu_ack_d;
    logic          dbg_ack_q,     dbg_ack_d;
    logic          timeout_err_q, timeout_err_d;

    logic   pick_valid;
    grant_e pick_grant;

    rr_arb2 u_rr_arb2 (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .last_grant (last_grant_q),
        .pick_valid (pick_valid),
        .pick_grant (pick_grant)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        rom_addr_d    = rom_addr_q;
        wdog_d        = wdog_q;
        cpu_data_d    = cpu_data_q;
        dbg_data_d    = dbg_data_q;
        // Strobe-type outputs are high for exactly one cycle.
        rom_req_d     = 1'b0;
        cpu_ack_d     = 1'b0;
        dbg_ack_d     = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_grant;
                    rom_addr_d = (pick_grant == GNT_CPU) ? cpu_addr : dbg_addr;
                    // Registered so that rom_req is high during ISSUE.
                    rom_req_d  = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + 8'd1;
                // A real reply wins over a watchdog expiry in the same cycle.
                if (rom_ack) begin
                    if (grant_q == GNT_CPU) begin
                        cpu_data_d = rom_data;
                        cpu_ack_d  = 1'b1;
                    end else begin
                        dbg_data_d = rom_data;
                        dbg_ack_d  = 1'b1;
                    end
                    state_d = DONE;
                end else if (wdog_q == WDOG_LAST) begin
                    if (grant_q == GNT_CPU) begin
                        cpu_data_d = ERR_DATA;
                        cpu_ack_d  = 1'b1;
                    end else begin
                        dbg_data_d = ERR_DATA;
                        dbg_ack_d  = 1'b1;
                    end
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= GNT_CPU;
            last_grant_q  <= GNT_DBG;
            rom_addr_q    <= '0;
            rom_req_q     <= 1'b0;
            wdog_q        <= 8'd0;
            cpu_data_q    <= 16'd0;
            dbg_data_q    <= 16'd0;
            cpu_ack_q     <= 1'b0;
            dbg_ack_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            rom_addr_q    <= rom_addr_d;
            rom_req_q     <= rom_req_d;
            wdog_q        <= wdog_d;
            cpu_data_q    <= cpu_data_d;
            dbg_data_q    <= dbg_data_d;
            cpu_ack_q     <= cpu_ack_d;
            dbg_ack_q     <= dbg_ack_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign rom_req     = rom_req_q;
    assign rom_addr    = rom_addr_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_data    = cpu_data_q;
    assign dbg_ack     = dbg_ack_q;
    assign dbg_data    = dbg_data_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rom68k_arb.sv
// Bench for rom68k_arb: ROM modelled as a registered memory returning ~addr
// after a programmable number of cycles (0 = never replies).
module tb_rom68k_arb;
    import rom68k_pkg::*;

    localparam int AW      = 10;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, dbg_req;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic          cpu_ack, dbg_ack;
    logic [15:0]   cpu_data, dbg_data;
    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic          rom_ack = 1'b0;
    logic [15:0]   rom_data = 16'd0;
    logic          timeout_err;

    rom68k_arb #(.AW(AW), .TIMEOUT(TIMEOUT), .ERR_DATA(16'hFFFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ack     (cpu_ack),
        .cpu_data    (cpu_data),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_ack     (dbg_ack),
        .dbg_data    (dbg_data),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- ROM model ----------------
    int            rom_delay = 1;
    int            rom_cnt   = 0;
    logic [AW-1:0] rom_paddr = '0;
    always @(posedge clk) begin
        rom_ack <= 1'b0;
        if (rom_cnt != 0) begin
            rom_cnt <= rom_cnt - 1;
            if (rom_cnt == 1) begin
                rom_ack  <= 1'b1;
                rom_data <= ~{6'b0, rom_paddr};
            end
        end
        if (rom_req && rom_delay != 0) begin
            if (rom_delay == 1) begin
                rom_ack  <= 1'b1;
                rom_data <= ~{6'b0, rom_addr};
            end else begin
                rom_cnt   <= rom_delay - 1;
                rom_paddr <= rom_addr;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    // An access granted in cycle c issues in c+1 and completes (ack) at
    // issue + min(reply delay, TIMEOUT) + 1; the arbiter is free the cycle after.
    bit            check_en = 0;
    bit            m_busy   = 0;
    bit            m_gnt    = 0;   // 0 = CPU, 1 = DBG
    bit            m_last   = 1;
    int            m_issue  = 0;
    int            m_done   = 0;
    logic [AW-1:0] m_rom_addr = '0;
    logic [15:0]   m_cpu_data = 16'd0;
    logic [15:0]   m_dbg_data = 16'd0;
    logic [15:0]   m_next_data = 16'd0;
    bit            m_next_err = 0;

    // Observation records used by the directed literal checks.
    int   cpu_acks = 0, dbg_acks = 0, rom_reqs = 0;
    int   last_req_cyc = 0, last_cpu_ack_cyc = 0, last_dbg_ack_cyc = 0;
    bit   last_ack_err = 0;
    bit   cpu_seen = 0, dbg_seen = 0;
    bit   grant_log[$];
    logic [15:0] cpu_data_log[$];

    always @(negedge clk) begin
        if (check_en) begin
            bit done_now;
            bit any_ok;
            done_now = m_busy && (cyc == m_done);
            if (done_now) begin
                if (m_gnt == 0) m_cpu_data = m_next_data;
                else            m_dbg_data = m_next_data;
            end
            chk("rom_req",     rom_req,     m_busy && (cyc == m_issue));
            chk("rom_addr",    rom_addr,    m_rom_addr);
            chk("cpu_ack",     cpu_ack,     done_now && (m_gnt == 0));
            chk("dbg_ack",     dbg_ack,     done_now && (m_gnt == 1));
            chk("timeout_err", timeout_err, done_now && m_next_err);
            chk("cpu_data",    cpu_data,    m_cpu_data);
            chk("dbg_data",    dbg_data,    m_dbg_data);
            chk("ack_onehot",  cpu_ack & dbg_ack, 1'b0);
            if (rom_req)           chk("rom_req_in_issue", dut.state_q, ISSUE);
            if (cpu_ack | dbg_ack) chk("ack_in_done",      dut.state_q, DONE);

            if (rom_req) begin rom_reqs++; last_req_cyc = cyc; end
            if (cpu_ack) begin
                cpu_acks++; cpu_seen = 1; last_cpu_ack_cyc = cyc;
                last_ack_err = timeout_err;
                grant_log.push_back(1'b0); cpu_data_log.push_back(cpu_data);
                $display("cycle %0d: CPU ack data=%04h err=%0b", cyc, cpu_data, timeout_err);
            end
            if (dbg_ack) begin
                dbg_acks++; dbg_seen = 1; last_dbg_ack_cyc = cyc;
                last_ack_err = timeout_err;
                grant_log.push_back(1'b1);
                $display("cycle %0d: DBG ack data=%04h err=%0b", cyc, dbg_data, timeout_err);
            end

            if (done_now) begin
                m_last = m_gnt;
                m_busy = 0;
            end else if (!m_busy && (cpu_req || dbg_req)) begin
                if (cpu_req && dbg_req) m_gnt = !m_last;
                else                    m_gnt = dbg_req;
                m_busy     = 1;
                m_rom_addr = m_gnt ? dbg_addr : cpu_addr;
                m_issue    = cyc + 1;
                any_ok     = (rom_delay != 0) && (rom_delay <= TIMEOUT);
                m_done     = m_issue + (any_ok ? rom_delay : TIMEOUT) + 1;
                m_next_err = !any_ok;
                m_next_data = any_ok ? ~{6'b0, m_rom_addr} : 16'hFFFF;
            end
        end
        if (rst) begin
            m_busy = 0; m_last = 1; m_rom_addr = '0;
            m_cpu_data = 16'd0; m_dbg_data = 16'd0;
        end
    end

    // Requesters drop req on the edge after they see their ack, unless held.
    bit cpu_hold = 0, dbg_hold = 0;
    always @(posedge clk) begin
        #1;
        if (cpu_seen) begin cpu_seen = 0; if (!cpu_hold) cpu_req = 1'b0; end
        if (dbg_seen) begin dbg_seen = 0; if (!dbg_hold) dbg_req = 1'b0; end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_acks(input int target, input int budget, input string nm);
        int k = 0;
        while ((cpu_acks + dbg_acks) < target && k < budget) begin
            @(posedge clk); #1; k++;
        end
        chk(nm, ((cpu_acks + dbg_acks) >= target), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        int n, base, reqs0;
        rst = 1'b1; cpu_req = 0; dbg_req = 0; cpu_addr = '0; dbg_addr = '0;
        tick(3);
        rst = 1'b0; check_en = 1;
        @(negedge clk);
        chk("rst_cpu_ack",  cpu_ack,  1'b0);
        chk("rst_rom_req",  rom_req,  1'b0);
        chk("rst_cpu_data", cpu_data, 16'h0000);
        chk("rst_rom_addr", rom_addr, 10'h000);
        chk("rst_state",    dut.state_q, IDLE);
        @(posedge clk); #1;

        // 1: single CPU read, latency pinned.
        n = cyc; base = cpu_acks + dbg_acks;
        cpu_addr = 10'h005; cpu_req = 1'b1;
        wait_acks(base + 1, 20, "t1_ack_wait");
        chk("t1_rom_req_cyc", last_req_cyc, n + 1);
        chk("t1_ack_cyc",     last_cpu_ack_cyc, n + 3);
        chk("t1_data",        cpu_data, 16'hFFFA);
        tick(3);

        // 2a: simultaneous requests after reset: CPU first, DBG 4 cycles later.
        do_reset(); tick(1);
        base = cpu_acks + dbg_acks;
        cpu_addr = 10'h010; dbg_addr = 10'h020; cpu_req = 1'b1; dbg_req = 1'b1;
        wait_acks(base + 2, 30, "t2_ack_wait");
        chk("t2_dbg_after_cpu", last_dbg_ack_cyc - last_cpu_ack_cyc, 4);
        chk("t2_cpu_data", cpu_data, 16'hFFEF);
        chk("t2_dbg_data", dbg_data, 16'hFFDF);
        tick(3);

        // 2b: both held: grants alternate CPU / DBG / CPU.
        base = cpu_acks + dbg_acks;
        cpu_hold = 1; dbg_hold = 1; cpu_req = 1'b1; dbg_req = 1'b1;
        wait_acks(base + 3, 40, "t2b_ack_wait");
        cpu_req = 1'b0; dbg_req = 1'b0; cpu_hold = 0; dbg_hold = 0;
        chk("t2b_g0", grant_log[grant_log.size()-3], 1'b0);
        chk("t2b_g1", grant_log[grant_log.size()-2], 1'b1);
        chk("t2b_g2", grant_log[grant_log.size()-1], 1'b0);
        tick(3);

        // 3: ROM replies too late: error reply, late reply ignored.
        rom_delay = 20; base = cpu_acks + dbg_acks;
        cpu_addr = 10'h011; cpu_req = 1'b1;
        wait_acks(base + 1, 40, "t3_ack_wait");
        chk("t3_ack_delay", last_cpu_ack_cyc - last_req_cyc, TIMEOUT + 1);
        chk("t3_data",      cpu_data, 16'hFFFF);
        chk("t3_err",       last_ack_err, 1'b1);
        tick(10);
        chk("t3_late_ignored", cpu_acks + dbg_acks, base + 1);
        chk("t3_data_held",    cpu_data, 16'hFFFF);

        // 4: reset while waiting: no ack; next request normal.
        rom_delay = 5; base = cpu_acks + dbg_acks; reqs0 = rom_reqs;
        cpu_addr = 10'h022; cpu_req = 1'b1;
        tick(3);
        rst = 1'b1; cpu_req = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(12);
        chk("t4_no_ack",   cpu_acks + dbg_acks, base);
        chk("t4_one_req",  rom_reqs, reqs0 + 1);
        chk("t4_idle",     dut.state_q, IDLE);
        rom_delay = 1;
        cpu_req = 1'b1;
        wait_acks(base + 1, 20, "t4_ack_wait");
        chk("t4_data", cpu_data, 16'hFFDD);
        tick(3);

        // 5: reply lands on the watchdog's last cycle: real data, no error.
        rom_delay = TIMEOUT; base = cpu_acks + dbg_acks;
        dbg_addr = 10'h0F0; dbg_req = 1'b1;
        wait_acks(base + 1, 40, "t5_ack_wait");
        chk("t5_ack_delay", last_dbg_ack_cyc - last_req_cyc, TIMEOUT + 1);
        chk("t5_data",      dbg_data, 16'hFF0F);
        chk("t5_err",       last_ack_err, 1'b0);
        tick(3);

        // 6: back-to-back CPU reads at the address extremes.
        rom_delay = 1; base = cpu_acks + dbg_acks;
        cpu_hold = 1; cpu_addr = 10'h3FF; cpu_req = 1'b1;
        wait_acks(base + 1, 20, "t6_ack1_wait");
        cpu_addr = 10'h000;
        wait_acks(base + 2, 20, "t6_ack2_wait");
        cpu_req = 1'b0; cpu_hold = 0;
        chk("t6_d0", cpu_data_log[cpu_data_log.size()-2], 16'hFC00);
        chk("t6_d1", cpu_data_log[cpu_data_log.size()-1], 16'hFFFF);
        chk("t6_rom_addr", rom_addr, 10'h000);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
